regfile_2r1w: RTL and testbench

//  Parametrised 2-read/1-write register file; next generation of the bit-cell register array.

---
 rtl/regfile_2r1w.sv | 123 ++++++++++++
 tb/tb_regfile_2r1w.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file with registered read ports and a bulk-clear engine.
// Optional write-through read bypass: define REGFILE_WR_BYPASS_EN.
module regfile_2r1w #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_req,
    output logic             clr_busy,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic             rd_en1,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    input  logic             rd_en2,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data2
);

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [0:0]       state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] rd_next1;
    logic [WIDTH-1:0] rd_next2;
    logic             wr_blocked;

    assign clr_busy   = (state == S_CLEAR);
    assign wr_ack     = wr_en && !clr_busy;
    assign wr_blocked = ZERO_REG && (wr_addr == '0);

    // Clear engine: walk the counter over every entry once, then go idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr_req) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    cnt <= cnt + ONE;
                    if (cnt == LAST) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Storage array: clear engine owns the array while busy, else the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_busy) begin
            mem[cnt] <= '0;
        end else if (wr_ack && !wr_blocked) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-port select: disabled ports return zero, entry 0 beats the bypass.
    always_comb begin
        rd_next1 = '0;
        rd_next2 = '0;
        if (rd_en1) begin
            if (ZERO_REG && rd_addr1 == '0) begin
                rd_next1 = '0;
            end else if (BYPASS && wr_ack && rd_addr1 == wr_addr) begin
                rd_next1 = wr_data;
            end else begin
                rd_next1 = mem[rd_addr1];
            end
        end
        if (rd_en2) begin
            if (ZERO_REG && rd_addr2 == '0) begin
                rd_next2 = '0;
            end else if (BYPASS && wr_ack && rd_addr2 == wr_addr) begin
                rd_next2 = wr_data;
            end else begin
                rd_next2 = mem[rd_addr2];
            end
        end
    end

    // Registered read data, one cycle after the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            rd_data1 <= rd_next1;
            rd_data2 <= rd_next2;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w (WIDTH=16, DEPTH=16, ZERO_REG=1).
// Honours REGFILE_WR_BYPASS_EN when computing expected reads.
module tb_regfile_2r1w;

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic        rd_en1 = 1'b0;
    logic [3:0]  rd_addr1 = '0;
    logic [15:0] rd_data1;
    logic        rd_en2 = 1'b0;
    logic [3:0]  rd_addr2 = '0;
    logic [15:0] rd_data2;

    regfile_2r1w #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .clr_req(clr_req), .clr_busy(clr_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd_data2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [15:0] mdl [16];
    bit          m_busy;
    int          m_cnt;
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];
    bit          qa [$];
    bit          ack_seen;

    function automatic logic [15:0] mread(bit en, logic [3:0] a, bit ack,
                                          logic [3:0] wa, logic [15:0] wd);
        if (!en) return 16'h0;
        if (a == 4'd0) return 16'h0;
        if (BYP && ack && a == wa) return wd;
        return mdl[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
        m_busy = 1'b0;
        m_cnt = 0;
        q1.delete();
        q2.delete();
        qa.delete();
    endtask

    // Drive one cycle at edge+1, push expectations, advance to next edge+1.
    task automatic step(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                        input bit e1, input logic [3:0] a1,
                        input bit e2, input logic [3:0] a2, input bit clr);
        bit ack;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en1 = e1; rd_addr1 = a1; rd_en2 = e2; rd_addr2 = a2;
        clr_req = clr;
        #1;
        ack_seen = wr_ack;
        ack = we && !m_busy;
        qa.push_back(ack);
        q1.push_back(mread(e1, a1, ack, wa, wd));
        q2.push_back(mread(e2, a2, ack, wa, wd));
        if (m_busy) begin
            mdl[m_cnt] = 16'h0;
            if (m_cnt == 15) m_busy = 1'b0;
            m_cnt = (m_cnt + 1) % 16;
        end else begin
            if (ack && wa != 4'd0) mdl[wa] = wd;
            if (clr) begin
                m_busy = 1'b1;
                m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; clr_req = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] e1, e2;
        bit ea;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (clr_busy !== 1'b0 || rd_data1 !== 16'h0 || rd_data2 !== 16'h0)
            $display("FAIL reset_outputs busy=%b rd1=%h rd2=%h want 0", clr_busy, rd_data1, rd_data2);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) begin
            step(1'b0, 4'd0, 16'h0, 1'b1, 4'(a), 1'b1, 4'(15 - a), 1'b0);
            e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
            n_chk++;
            if (rd_data1 !== e1 || rd_data2 !== e2 || clr_busy !== 1'b0)
                $display("FAIL reset_read a=%0d rd1=%h rd2=%h busy=%b want %h %h 0",
                         a, rd_data1, rd_data2, clr_busy, e1, e2);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        logic [15:0] e1, e2;
        bit ea;
        step(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd5, 1'b0, 4'd5, 1'b0);
        e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
        n_chk++;
        if (ack_seen !== ea || rd_data1 !== e1 || rd_data2 !== e2)
            $display("FAIL wr5 ack=%b rd1=%h rd2=%h want %b %h %h",
                     ack_seen, rd_data1, rd_data2, ea, e1, e2);
        else n_pass++;
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b1, 4'd5, 1'b0);
        e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
        n_chk++;
        if (rd_data1 !== e1 || rd_data2 !== e2 || rd_data1 !== 16'hBEEF)
            $display("FAIL rd5 rd1=%h rd2=%h want %h %h", rd_data1, rd_data2, e1, e2);
        else n_pass++;
    endtask

    task automatic test_zero_bypass();
        logic [15:0] e1, e2;
        bit ea;
        step(1'b1, 4'd0, 16'h1234, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
        n_chk++;
        if (rd_data1 !== e1) $display("FAIL zero_wr_rd rd1=%h want %h", rd_data1, e1);
        else n_pass++;
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0);
        e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
        n_chk++;
        if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0)
            $display("FAIL zero_rd rd1=%h rd2=%h want 0000", rd_data1, rd_data2);
        else n_pass++;
        step(1'b1, 4'd3, 16'hA5A5, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0);
        e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
        n_chk++;
        if (ack_seen !== ea || rd_data1 !== e1 || rd_data2 !== e2)
            $display("FAIL bypass3 ack=%b rd1=%h rd2=%h want %b %h %h",
                     ack_seen, rd_data1, rd_data2, ea, e1, e2);
        else n_pass++;
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
        n_chk++;
        if (rd_data1 !== e1 || rd_data2 !== e2)
            $display("FAIL after3 rd1=%h rd2=%h want %h %h", rd_data1, rd_data2, e1, e2);
        else n_pass++;
    endtask

    task automatic test_clear();
        logic [15:0] e1, e2;
        bit ea;
        int busy_n = 0;
        for (int a = 1; a < 16; a++) begin
            step(1'b1, 4'(a), 16'(a * 16'h0101), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
            e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
            n_chk++;
            if (ack_seen !== ea) $display("FAIL fill_ack a=%0d got %b want %b", a, ack_seen, ea);
            else n_pass++;
        end
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
        if (clr_busy === 1'b1) busy_n++;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'd7, 16'hFFFF, 1'b1, 4'(15 - i), 1'b1, 4'd9, 1'b0);
            e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
            if (clr_busy === 1'b1) busy_n++;
            n_chk++;
            if (ack_seen !== ea || rd_data1 !== e1 || rd_data2 !== e2 || clr_busy !== m_busy)
                $display("FAIL clr_cyc i=%0d ack=%b rd1=%h rd2=%h busy=%b want %b %h %h %b",
                         i, ack_seen, rd_data1, rd_data2, clr_busy, ea, e1, e2, m_busy);
            else n_pass++;
        end
        n_chk++;
        if (busy_n != 16) $display("FAIL clr_busy_len got %0d want 16", busy_n);
        else n_pass++;
        for (int a = 0; a < 16; a += 2) begin
            step(1'b0, 4'd0, 16'h0, 1'b1, 4'(a), 1'b1, 4'(a + 1), 1'b0);
            e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
            n_chk++;
            if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0 || rd_data1 !== e1 || rd_data2 !== e2)
                $display("FAIL clr_after a=%0d rd1=%h rd2=%h want 0000", a, rd_data1, rd_data2);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [15:0] e1, e2;
        bit ea;
        step(1'b1, 4'd2, 16'h1111, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        void'(q1.pop_front()); void'(q2.pop_front()); void'(qa.pop_front());
        step(1'b1, 4'd9, 16'h2222, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        void'(q1.pop_front()); void'(q2.pop_front()); void'(qa.pop_front());
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0, i == 0);
            void'(q1.pop_front()); void'(q2.pop_front()); void'(qa.pop_front());
        end
        n_chk++;
        if (clr_busy !== 1'b1) $display("FAIL mid_busy got %b want 1", clr_busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (clr_busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", clr_busy);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a += 2) begin
            step(1'b0, 4'd0, 16'h0, 1'b1, 4'(a), 1'b1, 4'(a + 1), 1'b0);
            e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
            n_chk++;
            if (rd_data1 !== e1 || rd_data2 !== e2 || rd_data2 !== 16'h0)
                $display("FAIL mid_after a=%0d rd1=%h rd2=%h want 0000", a, rd_data1, rd_data2);
            else n_pass++;
        end
        step(1'b1, 4'd4, 16'h4444, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        void'(q1.pop_front()); void'(q2.pop_front()); ea = qa.pop_front();
        n_chk++;
        if (clr_busy !== 1'b1 || ack_seen !== ea)
            $display("FAIL reclr_start busy=%b ack=%b want 1 %b", clr_busy, ack_seen, ea);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b1);
            e1 = q1.pop_front(); void'(q2.pop_front()); void'(qa.pop_front());
            n_chk++;
            if (clr_busy !== m_busy || rd_data1 !== e1)
                $display("FAIL reclr i=%0d busy=%b rd1=%h want %b %h",
                         i, clr_busy, rd_data1, m_busy, e1);
            else n_pass++;
        end
    endtask

    task automatic test_rd_en();
        logic [15:0] e1, e2;
        bit ea;
        step(1'b1, 4'd7, 16'h00FF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        void'(q1.pop_front()); void'(q2.pop_front()); void'(qa.pop_front());
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd7, 1'b1, 4'd7, 1'b0);
        e1 = q1.pop_front(); e2 = q2.pop_front(); ea = qa.pop_front();
        n_chk++;
        if (rd_data1 !== e1 || rd_data2 !== e2 || rd_data2 !== 16'h00FF)
            $display("FAIL rd_en rd1=%h rd2=%h want %h %h", rd_data1, rd_data2, e1, e2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_bypass();
        test_clear();
        test_reset_mid_clear();
        test_rd_en();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
